// File: rtl/meta_array_ctrl_pkg.sv
// Shared defaults and state encoding for the metadata array controller.
package meta_array_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W       = 6;
  localparam int unsigned DEF_DATA_W       = 66;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned STARVE_W         = 4;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

endpackage

// File: rtl/resp_hold_buf.sv
// One-entry read response slot: passes SRAM data through on the cycle after
// a read, and parks it in hold_reg if the consumer stalls.
module resp_hold_buf
  import meta_array_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_accept,
  input  logic              resp_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);

  logic              hold_q;
  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      hold_q     <= 1'b0;
      hold_reg   <= '0;
    end else if (rd_accept) begin
      // a new read is only accepted when the slot drains this cycle
      resp_valid <= 1'b1;
      hold_q     <= 1'b0;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
      hold_q     <= 1'b0;
    end else if (resp_valid && !hold_q) begin
      hold_q   <= 1'b1;
      hold_reg <= sram_rdata;
    end
  end

  assign resp_data = hold_q ? hold_reg : sram_rdata;

endmodule

// File: rtl/meta_array_ctrl.sv
// Single-port SRAM controller: clears the array after reset, then arbitrates
// one reader and one writer with write priority and a read-starvation guard.
module meta_array_ctrl
  import meta_array_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W       = DEF_ADDR_W,
  parameter int unsigned        DATA_W       = DEF_DATA_W,
  parameter int unsigned        STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter logic [DATA_W-1:0]  INIT_VALUE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  ctrl_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    init_cnt;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 slot_free;
  logic                 rd_elig;
  logic                 wr_grant;
  logic                 rd_grant;

  always_comb begin
    slot_free = !resp_valid || resp_ready;
    rd_elig   = (state_q == RUN) && rd_valid && slot_free;
    wr_grant  = (state_q == RUN) && wr_valid && !(rd_elig && (starve_cnt == LIMIT));
    rd_grant  = rd_elig && !wr_grant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_done  = 1'b0;
    rd_ready   = 1'b0;
    wr_ready   = 1'b0;
    sram_wen   = 1'b0;
    sram_ren   = 1'b0;
    sram_addr  = '0;
    sram_wdata = wr_data;
    case (state_q)
      INIT: begin
        sram_wen   = 1'b1;
        sram_addr  = init_cnt;
        sram_wdata = INIT_VALUE;
        if (init_cnt == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
        rd_ready  = rd_grant;
        wr_ready  = wr_grant;
        if (wr_grant) begin
          sram_wen  = 1'b1;
          sram_addr = wr_addr;
        end else if (rd_grant) begin
          sram_ren  = 1'b1;
          sram_addr = rd_addr;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state_q == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Counts cycles a ready-to-go read lost to a write; a full slot does not count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (rd_grant) begin
      starve_cnt <= '0;
    end else if (rd_elig && wr_grant && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  resp_hold_buf #(
    .DATA_W(DATA_W)
  ) u_resp_hold_buf (
    .clock      (clock),
    .reset      (reset),
    .rd_accept  (rd_grant),
    .resp_ready (resp_ready),
    .sram_rdata (sram_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

endmodule

// File: tb/tb_meta_array_ctrl.sv
// Self-checking bench for meta_array_ctrl: behavioural array/arbiter model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_meta_array_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 66;
  localparam int unsigned LIM   = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_valid = 1'b0, rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          resp_valid, resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_wen, sram_ren;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  always #5 clock = ~clock;

  meta_array_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM),
    .INIT_VALUE   ('0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_wen   (sram_wen),
    .sram_ren   (sram_ren),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Environment SRAM: garbage contents during reset, garbage rdata when no read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] <= DW'({$urandom, $urandom, $urandom}) | 1;
    end else if (sram_wen) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
    if (sram_ren) sram_rdata <= sram_mem[sram_addr];
    else          sram_rdata <= DW'({$urandom, $urandom, $urandom});
  end

  // Behavioural model
  bit            m_init;
  int unsigned   m_cnt;
  int unsigned   m_starve;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_rv;
  logic [DW-1:0] m_rd;
  bit            g_w, g_r, g_e;
  logic          seen_wr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_init;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init   = 1'b1;
    m_cnt    = 0;
    m_starve = 0;
    m_rv     = 1'b0;
  endtask

  task automatic check_cycle();
    logic [AW-1:0] e_addr;
    if (m_init) begin
      g_w = 1'b0; g_r = 1'b0; g_e = 1'b0;
      chk("init_wen", sram_wen, 1);
      chk("init_ren", sram_ren, 0);
      chk("init_addr", sram_addr, DW'(m_cnt));
      chk("init_wdata", sram_wdata, '0);
      chk("init_rd_ready", rd_ready, 0);
      chk("init_wr_ready", wr_ready, 0);
      chk("init_done_low", init_done, 0);
    end else begin
      g_e = rd_valid && (!m_rv || resp_ready);
      g_w = wr_valid && !(g_e && m_starve == LIM);
      g_r = g_e && !g_w;
      e_addr = g_w ? wr_addr : (g_r ? rd_addr : '0);
      chk("init_done_high", init_done, 1);
      chk("rd_ready", rd_ready, g_r);
      chk("wr_ready", wr_ready, g_w);
      chk("sram_wen", sram_wen, g_w);
      chk("sram_ren", sram_ren, g_r);
      chk("sram_addr", sram_addr, e_addr);
      if (g_w) chk("sram_wdata", sram_wdata, wr_data);
    end
    chk("resp_valid", resp_valid, m_rv);
    if (m_rv) chk("resp_data", resp_data, m_rd);
    seen_wr = wr_ready;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_init) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
    end else begin
      if (g_r) begin
        m_rv     = 1'b1;
        m_rd     = m_mem[rd_addr];
        m_starve = 0;
      end else begin
        if (m_rv && resp_ready) m_rv = 1'b0;
        if (g_e && g_w && m_starve < LIM) m_starve++;
      end
      if (g_w) m_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic run_init(input string name);
    n_init = 0;
    while (!init_done && n_init < 200) begin
      tick();
      n_init++;
    end
    chk(name, DW'(n_init), 64);
  endtask

  logic [DW-1:0] k_val, a_val, b_val;
  logic [9:0]    pat;

  initial begin
    model_reset();
    #2;
    chk("rst_wen", sram_wen, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rd_ready", rd_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    run_init("init_cycles");

    // Whole array reads back as the init value
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_valid = 1'b1;
      rd_addr  = AW'(a);
      tick();
      chk("readback_valid", resp_valid, 1);
      chk("readback_zero", resp_data, '0);
    end
    idle_inputs();
    tick();

    // Write then read-after-write to the same address
    k_val = 66'h2_DEAD_BEEF_0123_4567;
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = k_val;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5;
    tick();
    rd_valid = 1'b0;
    chk("raw_valid", resp_valid, 1);
    chk("raw_data", resp_data, k_val);
    tick();

    // Starvation guard: four writes, then the waiting read
    for (int i = 0; i < 10; i++) begin
      rd_valid = 1'b1; rd_addr = AW'($urandom_range(0, 15));
      wr_valid = 1'b1; wr_addr = AW'(20 + i); wr_data = DW'({$urandom, $urandom, $urandom});
      tick();
      pat[i] = seen_wr;
    end
    chk("starve_pattern", DW'(pat), DW'(10'b0111101111));
    idle_inputs();
    tick();

    // Stalled response holds old data while the entry is overwritten
    a_val = 66'h1_0000_AAAA_5555_0001;
    b_val = 66'h3_FFFF_BBBB_CCCC_0002;
    wr_valid = 1'b1; wr_addr = 6'd9; wr_data = a_val;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd9;
    tick();
    for (int i = 0; i < 3; i++) begin
      resp_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 6'd9;
      wr_valid = (i == 0); wr_addr = 6'd9; wr_data = b_val;
      #1;
      chk("hold_rd_ready", rd_ready, 0);
      chk("hold_data", resp_data, a_val);
      tick();
    end
    wr_valid = 1'b0; resp_ready = 1'b1; rd_valid = 1'b1; rd_addr = 6'd9;
    #1;
    chk("release_rd_ready", rd_ready, 1);
    chk("release_data", resp_data, a_val);
    tick();
    rd_valid = 1'b0;
    chk("new_data", resp_data, b_val);
    tick();

    // Streamed reads, one response per cycle in order
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = DW'(100 + i);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_addr = AW'(i);
      tick();
      chk("stream_valid", resp_valid, 1);
      chk("stream_data", resp_data, DW'(100 + i));
    end
    idle_inputs();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rd_valid   = ($urandom_range(0, 3) != 0);
      rd_addr    = AW'($urandom_range(0, 7));
      wr_valid   = ($urandom_range(0, 2) != 0);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = DW'({$urandom, $urandom, $urandom});
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Reset with a pending response
    rd_valid = 1'b1; rd_addr = 6'd3; resp_ready = 1'b0;
    tick();
    rd_valid = 1'b0;
    chk("pre_reset_valid", resp_valid, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_resp_valid", resp_valid, 0);
    chk("async_init_done", init_done, 0);
    chk("async_wen", sram_wen, 1);
    resp_ready = 1'b1;
    tick();
    reset = 1'b0;
    run_init("reinit_cycles");
    for (int a = 0; a < 8; a++) begin
      rd_valid = 1'b1;
      rd_addr  = AW'(a);
      tick();
      chk("reclear_zero", resp_data, '0);
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/meta_array_ctrl.md
# meta_array_ctrl

Controller and arbiter for a 64-entry × 66-bit single-port SRAM array (one shared address, one access per cycle). On reset it clears every entry to a known value, then shares the single port between one read requester and one write requester, with write priority bounded by a read-starvation guard. It returns read data through a one-entry backpressured response slot. It sits between the cache pipeline (requesters) and the SRAM array instance.

## Interface
- ADDR_W, 6, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 66, SRAM word width.
- STARVE_LIMIT, 4, consecutive write-lost cycles after which a waiting read wins; range 1..15.
- INIT_VALUE, 0, word written to every entry during initialisation.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_valid / rd_ready  in / out  1 / 1  read request handshake.
- rd_addr  in  ADDR_W  read address.
- wr_valid / wr_ready  in / out  1 / 1  write request handshake.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- resp_valid / resp_ready  out / in  1 / 1  read response handshake.
- resp_data  out  DATA_W  read response data.
- init_done  out  1  high once the clear sweep has finished.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wen  out  1  SRAM write enable.
- sram_ren  out  1  SRAM read enable.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_ren.

## Operation
- FSM states: INIT and RUN. Reset enters INIT with init_cnt = 0.
- INIT: each cycle drive sram_wen=1, sram_addr=init_cnt, sram_wdata=INIT_VALUE, then increment init_cnt. After the write to address 2^ADDR_W−1, go to RUN. rd_ready and wr_ready are 0 throughout INIT.
- RUN: init_done=1. At most one SRAM access per cycle.
- slot_free = !resp_valid || resp_ready.
- Read eligible = rd_valid && slot_free.
- Grant rule:
  - Write only valid: write wins.
  - Read eligible only: read wins.
  - Both: write wins unless starve_cnt == STARVE_LIMIT, in which case read wins.
- rd_ready = read granted. wr_ready = write granted. The ready signals are combinational from the valids and never depend on their own handshake.
- Granted write: sram_wen=1, sram_addr=wr_addr, sram_wdata=wr_data.
- Granted read: sram_ren=1, sram_addr=rd_addr.
- Idle cycle: sram_wen=0, sram_ren=0, sram_addr=0.
- starve_cnt (4 bits):
  - Clears on read acceptance.
  - Increments, saturating at STARVE_LIMIT, when the read is eligible but the write wins.
  - Holds otherwise, including when the read is blocked only by a full slot.
- Response slot:
  - A read accepted in cycle T sets resp_valid in T+1, with resp_data = sram_rdata (pass-through).
  - If resp_ready is low in T+1, sram_rdata is captured into hold_reg at the end of T+1. resp_data then comes from hold_reg until the response is consumed.
  - If resp_valid && resp_ready and no new read was accepted that cycle, resp_valid clears.
  - Back-to-back reads with resp_ready held high give one response per cycle.
- Read-after-write to the same address in the following cycle returns the new data (the SRAM is already updated). A same-cycle conflict cannot occur.

## Timing
- Reset values (asynchronous): state=INIT, init_cnt=0, starve_cnt=0, resp_valid=0, hold flag=0, init_done=0, rd_ready=0, wr_ready=0, sram_wen=1, sram_ren=0, sram_addr=0, sram_wdata=INIT_VALUE.
- init_done rises exactly 2^ADDR_W cycles after the first rising edge with reset low (64 cycles at the defaults).
- Read latency: request accepted in cycle T → resp_valid in T+1.
- Write takes effect at the edge ending the grant cycle.
- Reset asserted mid-operation: the pending response is dropped and the in-flight handshake is discarded. The controller restarts INIT and re-clears the whole array.

## Structure
- Shared package: ADDR_W and DATA_W defaults, the state enum {INIT, RUN}, and the STARVE_LIMIT default.
- One sub-module: resp_hold_buf. It holds the resp_valid flag, the hold flag and hold_reg, and implements the pass-through-or-hold response mux.
- The top level contains the FSM, init_cnt, starve_cnt, the arbiter and the SRAM port muxing.

## Test plan
- Reset release, then idle: sram_wen=1 for 64 cycles on addresses 0..63 with data 0; init_done rises at cycle 64; all 64 entries read back as 0.
- Write addr 5 = 0x2_DEAD_BEEF_0123_4567 in cycle T, read addr 5 in T+1 → resp_valid in T+2 with exactly that data.
- rd_valid and wr_valid held high continuously with STARVE_LIMIT=4: writes granted in 4 cycles, then the read in the 5th cycle; the pattern repeats, and starve_cnt returns to 0 after each read.
- resp_ready held low for 3 cycles after a read of addr 9, while a write to addr 9 occurs meanwhile: resp_data stays at the old value (from hold_reg); rd_ready=0 throughout; the next read is accepted in the same cycle resp_ready rises.
- Reads streamed to addresses 0..7 with resp_ready=1: 8 responses in 8 consecutive cycles, in order.
- reset asserted while resp_valid=1: resp_valid and init_done drop immediately; after release a full 64-cycle INIT sweep re-clears the array.
